// File: rtl/mult_div_unit.sv
// Iterative unsigned multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide share one control path; one iteration per cycle.
module mult_div_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] f
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [1:0]           op_r;
    logic [WIDTH-1:0]     mcand_r;
    logic [WIDTH-1:0]     div_r;
    logic [2*WIDTH-1:0]   prod_r;
    logic [WIDTH-1:0]     rem_r;
    logic [WIDTH-1:0]     quo_r;
    logic [WIDTH-1:0]     f_r;

    logic                 accept_s;
    logic                 last_s;
    logic [WIDTH:0]       add_s;
    logic [2*WIDTH-1:0]   prod_next_s;
    logic [WIDTH:0]       rem_sh_s;
    logic [WIDTH+1:0]     diff_s;
    logic [WIDTH-1:0]     rem_next_s;
    logic [WIDTH-1:0]     quo_next_s;
    logic [WIDTH-1:0]     result_s;

    // Next-state decode and new-operation acceptance
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        last_s   = (cnt_r == CNT_W'(WIDTH - 1));
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = BUSY;
                end else begin
                    state_s  = IDLE;
                end
            end
            BUSY: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = BUSY;
                end else begin
                    state_s  = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // One multiply and one divide iteration computed side by side every cycle
    always_comb begin
        add_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
        if (prod_r[0]) begin
            prod_next_s = {add_s, prod_r[WIDTH-1:1]};
        end else begin
            prod_next_s = {1'b0, prod_r[2*WIDTH-1:1]};
        end
        // Extra borrow bit: the shifted remainder can exceed WIDTH bits
        rem_sh_s = {rem_r, quo_r[WIDTH-1]};
        diff_s   = {1'b0, rem_sh_s} - {2'b00, div_r};
        if (diff_s[WIDTH+1]) begin
            rem_next_s = rem_sh_s[WIDTH-1:0];
            quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
        end else begin
            rem_next_s = diff_s[WIDTH-1:0];
            quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
        end
        case (op_r)
            2'b00:   result_s = prod_next_s[WIDTH-1:0];
            2'b01:   result_s = prod_next_s[2*WIDTH-1:WIDTH];
            2'b10:   result_s = quo_next_s;
            default: result_s = rem_next_s;
        endcase
    end

    // State, operand and iteration registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= 2'b00;
            mcand_r <= {WIDTH{1'b0}};
            div_r   <= {WIDTH{1'b0}};
            prod_r  <= {(2*WIDTH){1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= {WIDTH{1'b0}};
            f_r     <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                cnt_r   <= {CNT_W{1'b0}};
                op_r    <= op;
                mcand_r <= a;
                div_r   <= b;
                prod_r  <= {{WIDTH{1'b0}}, b};
                rem_r   <= {WIDTH{1'b0}};
                quo_r   <= a;
            end else if (state_r == BUSY) begin
                cnt_r  <= cnt_r + CNT_W'(1);
                prod_r <= prod_next_s;
                rem_r  <= rem_next_s;
                quo_r  <= quo_next_s;
                if (last_s) begin
                    f_r <= result_s;
                end else begin
                    f_r <= f_r;
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign busy  = (state_r == BUSY);
    assign done  = (state_r == DONE);
    assign stall = busy | (start & ~busy);
    assign f     = f_r;

endmodule
